base_address_wr: RTL and testbench

Write-side counterpart of the base-address BRAM reader. Accepts a counted burst of 32-bit result words on a valid/ready stream. Writes them to a PS-shared BRAM port at consecutive word addresses from `START_ADDR`. After the last data word it writes a completion flag word and raises `Transfer_Done` for the PS-side poller.

---
 rtl/base_address_wr_if.sv | 25 ++
 rtl/base_address_wr.sv | 72 +++++++
 tb/tb_base_address_wr.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/base_address_wr_if.sv
// base_address_wr_if: stream input and BRAM write port bundle for base_address_wr
interface base_address_wr_if;
  logic        start;
  logic [15:0] word_count;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        ram_clk;
  logic        ram_rst;
  logic [31:0] ram_addr;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_wd_data;
  logic [31:0] ram_rd_data;
  logic        busy;
  logic        Transfer_Done;
  modport master (
    output start, word_count, s_data, s_valid, ram_rd_data,
    input  s_ready, ram_clk, ram_rst, ram_addr, ram_en, ram_we, ram_wd_data, busy, Transfer_Done
  );
  modport slave (
    input  start, word_count, s_data, s_valid, ram_rd_data,
    output s_ready, ram_clk, ram_rst, ram_addr, ram_en, ram_we, ram_wd_data, busy, Transfer_Done
  );
endinterface

// File: rtl/base_address_wr.sv
// base_address_wr: writes a counted stream burst to BRAM, then a completion flag word
module base_address_wr #(
  parameter logic [31:0] START_ADDR = 32'h4580_0000,
  parameter int          MAX_WORDS  = 1024,
  parameter logic [31:0] FLAG_VALUE = 32'hA5A5_0001
) (
  input logic         clk,
  input logic         rst,
  base_address_wr_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, FLAG, DONE} state_t;
  localparam logic [15:0] MAXW = 16'(MAX_WORDS);
  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d, cnt_q, cnt_d, clamp;
  logic        en_q, en_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic        unused_rd;
  assign clamp = bus.word_count > MAXW ? MAXW : bus.word_count;
  assign unused_rd = ^bus.ram_rd_data;
  // next state, counters and the bus beat to present next cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    addr_d  = '0;
    data_d  = '0;
    if (state_q == WRITE && bus.s_valid) begin
      en_d    = 1'b1;
      addr_d  = START_ADDR + 32'({idx_q, 2'b00});
      data_d  = bus.s_data;
      idx_d   = idx_q + 16'd1;
      state_d = idx_q == cnt_q - 16'd1 ? FLAG : WRITE;
    end else if (state_q == FLAG) begin
      en_d    = 1'b1;
      addr_d  = START_ADDR + 32'({cnt_q, 2'b00});
      data_d  = FLAG_VALUE;
      state_d = DONE;
    end else if ((state_q == IDLE || state_q == DONE) && bus.start) begin
      cnt_d   = clamp;
      idx_d   = '0;
      state_d = clamp != 16'd0 ? WRITE : FLAG;
    end
  end
  // state and registered BRAM outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end
  assign bus.s_ready       = state_q == WRITE;
  assign bus.busy          = state_q == WRITE || state_q == FLAG;
  assign bus.Transfer_Done = state_q == DONE;
  assign bus.ram_clk       = clk;
  assign bus.ram_rst       = 1'b0;
  assign bus.ram_en        = en_q;
  assign bus.ram_we        = {4{en_q}};
  assign bus.ram_addr      = addr_q;
  assign bus.ram_wd_data   = data_q;
endmodule

// File: tb/tb_base_address_wr.sv
// tb_base_address_wr: randomized and directed bench against a transaction-level model
module tb_base_address_wr;
  localparam logic [31:0] SA = 32'h4580_0000;
  localparam logic [31:0] FV = 32'hA5A5_0001;
  logic clk, rst;
  int checks = 0, failures = 0;
  base_address_wr_if ifc();
  base_address_wr dut (.clk(clk), .rst(rst), .bus(ifc));
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: phase 0 idle, 1 streaming, 2 flag pending, 3 complete
  int          m_phase = 0, m_n = 0, m_k = 0;
  logic        m_en = 1'b0;
  logic [31:0] m_addr = '0, m_data = '0;
  bit          armed = 1'b0;
  logic [63:0] log_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    armed = 1'b1;
    m_en = 1'b0; m_addr = '0; m_data = '0;
    if (rst) begin
      m_phase = 0; m_n = 0; m_k = 0;
    end else if (m_phase == 1 && ifc.s_valid) begin
      m_en = 1'b1; m_addr = SA + 32'(4 * m_k); m_data = ifc.s_data;
      m_k++;
      if (m_k == m_n) m_phase = 2;
    end else if (m_phase == 2) begin
      m_en = 1'b1; m_addr = SA + 32'(4 * m_n); m_data = FV;
      m_phase = 3;
    end else if ((m_phase == 0 || m_phase == 3) && ifc.start) begin
      m_n = ifc.word_count > 16'd1024 ? 1024 : int'(ifc.word_count);
      m_k = 0;
      m_phase = m_n != 0 ? 1 : 2;
    end
  end

  always @(negedge clk) if (armed) begin
    chk("cycle",
        {ifc.s_ready, ifc.busy, ifc.Transfer_Done, ifc.ram_rst, ifc.ram_en, ifc.ram_we, ifc.ram_addr, ifc.ram_wd_data},
        {m_phase == 1, m_phase == 1 || m_phase == 2, m_phase == 3, 1'b0, m_en, m_en ? 4'hF : 4'h0, m_addr, m_data});
    if (ifc.ram_en === 1'b1) log_q.push_back({ifc.ram_addr, ifc.ram_wd_data});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (m_phase == 3) break;
      step();
    end
    @(negedge clk);
    #1;
    chk("wait_done", ifc.Transfer_Done, 1'b1);
  endtask

  initial begin
    ifc.start = 0; ifc.word_count = 0; ifc.s_data = 0; ifc.s_valid = 0; ifc.ram_rd_data = 0;
    rst = 1;
    step(); step();
    @(negedge clk);
    chk("reset_outs", {ifc.s_ready, ifc.busy, ifc.Transfer_Done, ifc.ram_rst, ifc.ram_en, ifc.ram_we, ifc.ram_addr, ifc.ram_wd_data}, '0);
    rst = 0;
    step();
    // back-to-back burst of four
    log_q.delete();
    ifc.start = 1; ifc.word_count = 4; step();
    ifc.start = 0; ifc.s_valid = 1;
    ifc.s_data = 32'h11; step();
    ifc.s_data = 32'h22; step();
    ifc.s_data = 32'h33; step();
    ifc.s_data = 32'h44; step();
    ifc.s_valid = 0;
    @(negedge clk);
    chk("b2b_done_l1", ifc.Transfer_Done, 1'b0);
    step();
    @(negedge clk);
    chk("b2b_done_l2", ifc.Transfer_Done, 1'b1);
    #1;
    chk("b2b_n", log_q.size(), 5);
    chk("b2b_0", log_q[0], 64'h4580_0000_0000_0011);
    chk("b2b_1", log_q[1], 64'h4580_0004_0000_0022);
    chk("b2b_2", log_q[2], 64'h4580_0008_0000_0033);
    chk("b2b_3", log_q[3], 64'h4580_000C_0000_0044);
    chk("b2b_flag", log_q[4], 64'h4580_0010_A5A5_0001);
    // stalled stream
    log_q.delete();
    ifc.start = 1; ifc.word_count = 3; step();
    ifc.start = 0;
    for (int i = 0; i < 6; i++) begin
      ifc.s_valid = (i == 0 || i == 3 || i == 5);
      ifc.s_data = $urandom;
      step();
    end
    ifc.s_valid = 0;
    wait_done(10);
    chk("stall_n", log_q.size(), 4);
    chk("stall_a0", log_q[0][63:32], 32'h4580_0000);
    chk("stall_a1", log_q[1][63:32], 32'h4580_0004);
    chk("stall_a2", log_q[2][63:32], 32'h4580_0008);
    chk("stall_flag", log_q[3], 64'h4580_000C_A5A5_0001);
    // empty burst
    log_q.delete();
    ifc.start = 1; ifc.word_count = 0; step();
    ifc.start = 0;
    @(negedge clk);
    chk("empty_c1", {ifc.busy, ifc.ram_en, ifc.Transfer_Done}, 3'b100);
    step();
    @(negedge clk);
    chk("empty_c2", {ifc.Transfer_Done, ifc.ram_en, ifc.ram_addr, ifc.ram_wd_data}, {2'b11, 32'h4580_0000, 32'hA5A5_0001});
    #1;
    chk("empty_n", log_q.size(), 1);
    // start ignored mid-write
    log_q.delete();
    ifc.start = 1; ifc.word_count = 5; step();
    ifc.start = 0; ifc.s_valid = 1; ifc.s_data = $urandom; step();
    ifc.s_data = $urandom; step();
    ifc.start = 1; ifc.word_count = 1; ifc.s_data = $urandom; step();
    ifc.start = 0;
    for (int i = 0; i < 10 && m_phase == 1; i++) begin
      ifc.s_data = $urandom; step();
    end
    ifc.s_valid = 0;
    wait_done(10);
    chk("ign_n", log_q.size(), 6);
    chk("ign_flag", log_q[5], {SA + 32'h14, FV});
    // clamp to MAX_WORDS
    log_q.delete();
    ifc.start = 1; ifc.word_count = 2000; step();
    ifc.start = 0;
    for (int i = 0; i < 3000 && m_phase == 1; i++) begin
      ifc.s_valid = ($urandom % 4) != 0; ifc.s_data = $urandom; step();
    end
    ifc.s_valid = 0;
    wait_done(10);
    chk("clamp_n", log_q.size(), 1025);
    chk("clamp_flag", log_q[1024], 64'h4580_1000_A5A5_0001);
    // reset mid-burst, restart, re-arm from DONE
    log_q.delete();
    ifc.start = 1; ifc.word_count = 4; step();
    ifc.start = 0; ifc.s_valid = 1; ifc.s_data = 32'hA; step();
    ifc.s_data = 32'hB; step();
    ifc.s_valid = 0; rst = 1; ifc.start = 1; step();
    rst = 0; ifc.start = 0; step(); step();
    @(negedge clk);
    chk("rst_n", log_q.size(), 2);
    chk("rst_outs", {ifc.busy, ifc.s_ready, ifc.Transfer_Done, ifc.ram_en, ifc.ram_addr}, '0);
    #1;
    log_q.delete();
    ifc.start = 1; ifc.word_count = 1; step();
    ifc.start = 0; ifc.s_valid = 1; ifc.s_data = 32'hDEAD_BEEF; step();
    ifc.s_valid = 0;
    wait_done(10);
    chk("restart_0", log_q[0], 64'h4580_0000_DEAD_BEEF);
    chk("restart_flag", log_q[1], 64'h4580_0004_A5A5_0001);
    ifc.start = 1; ifc.word_count = 3; step();
    ifc.start = 0;
    @(negedge clk);
    chk("rearm", {ifc.Transfer_Done, ifc.s_ready}, 2'b01);
    #1;
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 250) == 0;
      ifc.start = ($urandom % 12) == 0;
      ifc.word_count = ($urandom % 40 == 0) ? 16'($urandom) : 16'($urandom % 20);
      ifc.s_valid = ($urandom % 3) != 0;
      ifc.s_data = $urandom;
      step();
    end
    rst = 0; ifc.start = 0; ifc.s_valid = 0;
    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
